// File: rtl/ysyx_24100029_btb_pkg.sv
// Shared types for the BTB update controller: branch-type codes,
// the update record layout and the controller state encoding.
package ysyx_24100029_btb_pkg;

  localparam int BR_TYPE_W = 2;

  localparam logic [BR_TYPE_W-1:0] BR_NONE   = 2'd0;
  localparam logic [BR_TYPE_W-1:0] BR_BRANCH = 2'd1;
  localparam logic [BR_TYPE_W-1:0] BR_JAL    = 2'd2;
  localparam logic [BR_TYPE_W-1:0] BR_JALR   = 2'd3;

  // Field order matches the packed {pc, npc, type} word stored in the FIFO.
  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          npc;
    logic [BR_TYPE_W-1:0] br_type;
  } btb_upd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/ysyx_24100029_sync_fifo.sv
// Synchronous FIFO with push/pop/clear. Pointers are log2(DEPTH) bits and
// wrap naturally; a separate count (one bit wider) gives full/empty.
// Pushes while full and pops while empty are ignored.
module ysyx_24100029_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the queue in one edge
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write
  always_ff @(posedge clock) begin
    // NOTE: the storage array is not reset; count/pointers alone decide which entries are live.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_24100029_btb_upd_ctrl.sv
// BTB update controller: arbitrates EXU (priority) and IDU training updates
// into a FIFO, drains one entry per cycle to the BTB commit port, and walks
// every BTB set with an invalidate strobe after fence.i.
// Optional feature macro: YSYX_24100029_BTB_DEDUP_EN drops an accepted
// request identical to the previous accepted one.
module ysyx_24100029_btb_upd_ctrl
  import ysyx_24100029_btb_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INDEX_WIDTH = 3,
  parameter int TYPE_WIDTH  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   exu_upd_valid,
  output logic                   exu_upd_ready,
  input  logic [31:0]            exu_upd_pc,
  input  logic [31:0]            exu_upd_npc,
  input  logic [TYPE_WIDTH-1:0]  exu_upd_type,
  input  logic                   idu_upd_valid,
  output logic                   idu_upd_ready,
  input  logic [31:0]            idu_upd_pc,
  input  logic [31:0]            idu_upd_npc,
  input  logic [TYPE_WIDTH-1:0]  idu_upd_type,
  input  logic                   fence_i,
  output logic                   btb_commit,
  output logic [31:0]            btb_commit_pc,
  output logic [TYPE_WIDTH-1:0]  btb_commit_pc_type,
  output logic [31:0]            btb_commit_npc,
  output logic                   btb_inv,
  output logic [INDEX_WIDTH-1:0] btb_inv_index,
  output logic                   flush_busy
);

  localparam int UPD_W = 64 + TYPE_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

  ctrl_state_e            state;
  ctrl_state_e            state_nxt;
  logic [INDEX_WIDTH-1:0] inv_cnt;
  logic [INDEX_WIDTH-1:0] inv_cnt_nxt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_clear;
  logic [UPD_W-1:0]       req_data;
  logic [UPD_W-1:0]       head_data;
  logic                   exu_fire;
  logic                   idu_fire;
  logic                   req_dup;

  // State and walk counter; reset abandons any walk in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      inv_cnt <= '0;
    end else begin
      state   <= state_nxt;
      inv_cnt <= inv_cnt_nxt;
    end
  end

  // Next state, walk counter, handshakes, drain and invalidate strobes
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nxt     = state;
    inv_cnt_nxt   = inv_cnt;
    exu_upd_ready = 1'b0;
    idu_upd_ready = 1'b0;
    btb_commit    = 1'b0;
    btb_inv       = 1'b0;
    btb_inv_index = '0;
    flush_busy    = 1'b0;
    fifo_clear    = 1'b0;
    case (state)
      IDLE: begin
        // Full is the pre-pop occupancy, so a same-cycle pop never frees a slot.
        exu_upd_ready = !fifo_full && !fence_i;
        idu_upd_ready = exu_upd_ready && !exu_upd_valid;
        btb_commit    = !fifo_empty && !fence_i;
        if (fence_i) begin
          fifo_clear = 1'b1;
          state_nxt  = FLUSH;
        end
      end
      FLUSH: begin
        btb_inv       = 1'b1;
        btb_inv_index = inv_cnt;
        flush_busy    = 1'b1;
        inv_cnt_nxt   = inv_cnt + 1'b1;
        if (inv_cnt == LAST_INDEX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign exu_fire  = exu_upd_valid && exu_upd_ready;
  assign idu_fire  = idu_upd_valid && idu_upd_ready;
  assign req_data  = exu_fire ? {exu_upd_pc, exu_upd_npc, exu_upd_type}
                              : {idu_upd_pc, idu_upd_npc, idu_upd_type};
  assign fifo_push = (exu_fire || idu_fire) && !req_dup;

`ifdef YSYX_24100029_BTB_DEDUP_EN
  logic             last_vld;
  logic [UPD_W-1:0] last_data;

  // Remember the last accepted request; fence.i forgets it so retraining goes through
  always_ff @(posedge clock) begin
    if (reset || fence_i) begin
      last_vld <= 1'b0;
    end else if (exu_fire || idu_fire) begin
      last_vld  <= 1'b1;
      last_data <= req_data;
    end
  end

  assign req_dup = last_vld && (last_data == req_data);
`else
  assign req_dup = 1'b0;
`endif

  ysyx_24100029_sync_fifo #(
    .WIDTH (UPD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (req_data),
    .pop       (btb_commit),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {btb_commit_pc, btb_commit_npc, btb_commit_pc_type} = btb_commit ? head_data : '0;

endmodule

// File: tb/tb_ysyx_24100029_btb_upd_ctrl.sv
// Self-checking bench for ysyx_24100029_btb_upd_ctrl: a queue-based model
// checked on every falling edge, plus directed scenarios with literal
// expectations sampled 1 time unit after the rising edge.
module tb_ysyx_24100029_btb_upd_ctrl;
  import ysyx_24100029_btb_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 3;
  localparam int TW    = 2;
  localparam int NSETS = 1 << IW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          exu_upd_valid = 1'b0;
  logic          exu_upd_ready;
  logic [31:0]   exu_upd_pc = '0;
  logic [31:0]   exu_upd_npc = '0;
  logic [TW-1:0] exu_upd_type = '0;
  logic          idu_upd_valid = 1'b0;
  logic          idu_upd_ready;
  logic [31:0]   idu_upd_pc = '0;
  logic [31:0]   idu_upd_npc = '0;
  logic [TW-1:0] idu_upd_type = '0;
  logic          fence_i = 1'b0;
  logic          btb_commit;
  logic [31:0]   btb_commit_pc;
  logic [TW-1:0] btb_commit_pc_type;
  logic [31:0]   btb_commit_npc;
  logic          btb_inv;
  logic [IW-1:0] btb_inv_index;
  logic          flush_busy;

  ysyx_24100029_btb_upd_ctrl #(
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (IW),
    .TYPE_WIDTH  (TW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .exu_upd_valid      (exu_upd_valid),
    .exu_upd_ready      (exu_upd_ready),
    .exu_upd_pc         (exu_upd_pc),
    .exu_upd_npc        (exu_upd_npc),
    .exu_upd_type       (exu_upd_type),
    .idu_upd_valid      (idu_upd_valid),
    .idu_upd_ready      (idu_upd_ready),
    .idu_upd_pc         (idu_upd_pc),
    .idu_upd_npc        (idu_upd_npc),
    .idu_upd_type       (idu_upd_type),
    .fence_i            (fence_i),
    .btb_commit         (btb_commit),
    .btb_commit_pc      (btb_commit_pc),
    .btb_commit_pc_type (btb_commit_pc_type),
    .btb_commit_npc     (btb_commit_npc),
    .btb_inv            (btb_inv),
    .btb_inv_index      (btb_inv_index),
    .flush_busy         (flush_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [65:0] mq [$];
  int          flush_left = 0;
  bit          armed = 0;
  bit          last_vld = 0;
  logic [65:0] last_upd = '0;
  bit          m_idle, m_full, m_exu_rdy, m_idu_rdy, m_commit, m_acc;
  logic [65:0] m_head, m_req;
  int          m_idx;

  always @(negedge clock) begin
    m_idle    = (flush_left == 0);
    m_full    = (mq.size() == DEPTH);
    m_exu_rdy = m_idle && !m_full && !fence_i;
    m_idu_rdy = m_exu_rdy && !exu_upd_valid;
    m_commit  = m_idle && (mq.size() != 0) && !fence_i;
    m_head    = m_commit ? mq[0] : '0;
    m_idx     = m_idle ? 0 : NSETS - flush_left;
    if (armed) begin
      check("commit",     btb_commit,         m_commit);
      check("commit_pc",  btb_commit_pc,      m_head[65:34]);
      check("commit_npc", btb_commit_npc,     m_head[33:2]);
      check("commit_typ", btb_commit_pc_type, m_head[1:0]);
      check("exu_ready",  exu_upd_ready,      m_exu_rdy);
      check("idu_ready",  idu_upd_ready,      m_idu_rdy);
      check("inv",        btb_inv,            !m_idle);
      check("inv_index",  btb_inv_index,      m_idx);
      check("flush_busy", flush_busy,         !m_idle);
    end
    if (reset) begin
      mq.delete();
      flush_left = 0;
      last_vld   = 0;
      armed      = 1;
    end else if (armed) begin
      if (!m_idle) begin
        flush_left--;
      end else if (fence_i) begin
        mq.delete();
        flush_left = NSETS;
      end else begin
        if (m_commit) void'(mq.pop_front());
        m_acc = 0;
        m_req = '0;
        if (exu_upd_valid && m_exu_rdy) begin
          m_acc = 1;
          m_req = {exu_upd_pc, exu_upd_npc, exu_upd_type};
        end else if (idu_upd_valid && m_idu_rdy) begin
          m_acc = 1;
          m_req = {idu_upd_pc, idu_upd_npc, idu_upd_type};
        end
        if (m_acc) begin
`ifdef YSYX_24100029_BTB_DEDUP_EN
          if (!(last_vld && last_upd == m_req)) mq.push_back(m_req);
          last_vld = 1;
          last_upd = m_req;
`else
          mq.push_back(m_req);
`endif
        end
      end
      if (fence_i) last_vld = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  int ncommit;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check("rst_commit", btb_commit, 1'b0);
    check("rst_exu_rdy", exu_upd_ready, 1'b1);
    check("rst_idu_rdy", idu_upd_ready, 1'b1);
    check("rst_busy", flush_busy, 1'b0);
    check("rst_inv", btb_inv, 1'b0);
    reset = 1'b0;
    tick();

    // Single EXU push commits the next cycle, for one cycle
    exu_upd_valid = 1'b1;
    exu_upd_pc    = 32'h8000_0010;
    exu_upd_npc   = 32'h8000_0040;
    exu_upd_type  = BR_BRANCH;
    #1;
    check("t1_exu_rdy", exu_upd_ready, 1'b1);
    tick();
    exu_upd_valid = 1'b0;
    #1;
    check("t1_commit", btb_commit, 1'b1);
    check("t1_pc", btb_commit_pc, 32'h8000_0010);
    check("t1_npc", btb_commit_npc, 32'h8000_0040);
    check("t1_type", btb_commit_pc_type, BR_BRANCH);
    tick();
    check("t1_commit_once", btb_commit, 1'b0);
    check("t1_pc_zero", btb_commit_pc, 32'h0);

    // EXU priority over IDU
    exu_upd_valid = 1'b1;
    exu_upd_pc    = 32'h8000_0100;
    exu_upd_npc   = 32'h8000_0200;
    exu_upd_type  = BR_BRANCH;
    idu_upd_valid = 1'b1;
    idu_upd_pc    = 32'h8000_0108;
    idu_upd_npc   = 32'h8000_0400;
    idu_upd_type  = BR_JAL;
    #1;
    check("t2_idu_blocked", idu_upd_ready, 1'b0);
    tick();
    exu_upd_pc   = 32'h8000_0104;
    exu_upd_npc  = 32'h8000_0300;
    exu_upd_type = BR_JALR;
    #1;
    check("t2_idu_blocked2", idu_upd_ready, 1'b0);
    check("t2_first_pc", btb_commit_pc, 32'h8000_0100);
    tick();
    exu_upd_valid = 1'b0;
    #1;
    check("t2_second_pc", btb_commit_pc, 32'h8000_0104);
    check("t2_idu_rdy", idu_upd_ready, 1'b1);
    tick();
    idu_upd_valid = 1'b0;
    #1;
    check("t2_idu_pc", btb_commit_pc, 32'h8000_0108);
    check("t2_idu_type", btb_commit_pc_type, BR_JAL);
    tick();

    // Back-to-back pushes: drain keeps pace, ready stays high
    for (int i = 0; i < DEPTH; i++) begin
      exu_upd_valid = 1'b1;
      exu_upd_pc    = 32'h8000_1000 + 32'(4 * i);
      exu_upd_npc   = 32'h8000_2000 + 32'(16 * i);
      exu_upd_type  = BR_JAL;
      #1;
      check("t3_fill_ready", exu_upd_ready, 1'b1);
      tick();
    end
    exu_upd_valid = 1'b0;
    #1;
    check("t3_fill_last_pc", btb_commit_pc, 32'h8000_100C);
    tick();

    // fence.i with an entry queued and IDU held valid across the walk
    exu_upd_valid = 1'b1;
    exu_upd_pc    = 32'h8000_3000;
    exu_upd_npc   = 32'h8000_3100;
    exu_upd_type  = BR_BRANCH;
    tick();
    exu_upd_valid = 1'b0;
    fence_i       = 1'b1;
    idu_upd_valid = 1'b1;
    idu_upd_pc    = 32'h8000_4000;
    idu_upd_npc   = 32'h8000_5000;
    idu_upd_type  = BR_JAL;
    #1;
    check("t4_no_commit", btb_commit, 1'b0);
    check("t4_exu_rdy0", exu_upd_ready, 1'b0);
    tick();
    fence_i = 1'b0;
    for (int i = 0; i < NSETS; i++) begin
      #1;
      check("t4_inv", btb_inv, 1'b1);
      check("t4_index", btb_inv_index, i);
      check("t4_busy", flush_busy, 1'b1);
      check("t4_idu_rdy0", idu_upd_ready, 1'b0);
      if (i == 4) fence_i = 1'b1;
      if (i == 5) fence_i = 1'b0;
      tick();
    end
    #1;
    check("t4_idle_busy", flush_busy, 1'b0);
    check("t4_idle_rdy", idu_upd_ready, 1'b1);
    check("t4_cleared", btb_commit, 1'b0);
    tick();
    idu_upd_valid = 1'b0;
    #1;
    check("t4_resume_pc", btb_commit_pc, 32'h8000_4000);
    tick();

    // Reset mid-walk at index 3
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    repeat (3) tick();
    check("t5_index3", btb_inv_index, 3'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t5_inv", btb_inv, 1'b0);
    check("t5_busy", flush_busy, 1'b0);
    check("t5_empty", btb_commit, 1'b0);
    check("t5_rdy", exu_upd_ready, 1'b1);
    tick();

    // Identical update presented twice, then again after fence.i
    ncommit = 0;
    exu_upd_valid = 1'b1;
    exu_upd_pc    = 32'h8000_6000;
    exu_upd_npc   = 32'h8000_6100;
    exu_upd_type  = BR_BRANCH;
    tick();
    ncommit += int'(btb_commit);
    tick();
    ncommit += int'(btb_commit);
    exu_upd_valid = 1'b0;
    tick();
    ncommit += int'(btb_commit);
    tick();
    ncommit += int'(btb_commit);
`ifdef YSYX_24100029_BTB_DEDUP_EN
    check("t6_dedup_commits", ncommit, 1);
`else
    check("t6_plain_commits", ncommit, 2);
`endif
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    repeat (NSETS) tick();
    exu_upd_valid = 1'b1;
    tick();
    exu_upd_valid = 1'b0;
    #1;
    check("t6_recommit", btb_commit, 1'b1);
    check("t6_recommit_pc", btb_commit_pc, 32'h8000_6000);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
